// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator/measurement blocks: trigger edge
// encodings, measurement FSM states and a saturating increment.
package pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE     = 2'd0,
    EDGE_FALL     = 2'd1,
    EDGE_BOTH     = 2'd2,
    EDGE_RISE_ALT = 2'd3
  } trig_edge_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } meas_state_e;

  // Callers zero-extend into 64 bits and cast the result back to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    if (val >= max_val) begin
      sat_inc = max_val;
    end else begin
      sat_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pulse_measure_fifo.sv
// Synchronous FIFO with registered head data, valid and occupancy count.
// Simultaneous push and pop are both honoured even when full.
module pulse_measure_fifo #(
  parameter int DW = 96,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic          drop_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          full_s, do_push_s, do_pop_s;

  // Pointer/count update and selection of the next head entry.
  always_comb begin
    full_s    = (count_q == DEPTH_CNT);
    do_pop_s  = pop_i & (count_q != '0);
    do_push_s = push_i & (~full_s | do_pop_s);
    drop_o    = push_i & full_s & ~do_pop_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      // The new head is the entry being written now when nothing else remains.
      if (count_d == '0) begin
        data_d = data_q;
      end else if ((count_q == '0) || ((count_q == (AW+1)'(1)) && do_pop_s)) begin
        data_d = data_i;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
    valid_d = (count_d != '0);
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer, count and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/pulse_measure.sv
// Measures trigger-to-rise delay and high width of a pulse train and queues
// each (delay, width) pair for readout through a valid/ready port.
module pulse_measure
  import pulse_pkg::*;
#(
  parameter int CNT_W    = 48,
  parameter int QUEUE_AW = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             trig_i,
  input  logic             inp_i,
  input  logic [1:0]       TRIG_EDGE,
  input  logic             TRIG_EDGE_WSTB,
  output logic [CNT_W-1:0] delay_o,
  output logic [CNT_W-1:0] width_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      QUEUE,
  output logic [31:0]      MISSED_CNT,
  output logic [31:0]      ERR_OVERFLOW,
  output logic [31:0]      ERR_QUEUE
);

  localparam logic [63:0] CNT_MAX    = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                     : ((64'd1 << CNT_W) - 64'd1);
  localparam logic [63:0] MISSED_MAX = 64'h0000_0000_FFFF_FFFF;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, delay_q, delay_d;
  logic [31:0]      missed_q, missed_d;
  logic             trig_q, trig_d, inp_q, inp_d, en_q, en_d;
  logic             ovf_q, ovf_d, errq_q, errq_d;

  logic             trig_sel_s, inp_rise_s, inp_fall_s, en_rise_s, abort_s;
  logic [CNT_W-1:0] cnt_inc_s, width_s;
  logic             cnt_at_max_s, push_s, drop_s;
  logic [2*CNT_W-1:0] fifo_data_s;
  logic [QUEUE_AW:0]  fifo_count_s;

  // Edge detection against the previous-cycle samples.
  always_comb begin
    trig_d     = trig_i;
    inp_d      = inp_i;
    en_d       = enable_i;
    inp_rise_s = inp_i & ~inp_q;
    inp_fall_s = ~inp_i & inp_q;
    en_rise_s  = enable_i & ~en_q;
    abort_s    = ~enable_i | TRIG_EDGE_WSTB | en_rise_s;
    case (trig_edge_e'(TRIG_EDGE))
      EDGE_FALL: trig_sel_s = ~trig_i & trig_q;
      EDGE_BOTH: trig_sel_s = trig_i ^ trig_q;
      default:   trig_sel_s = trig_i & ~trig_q;
    endcase
    cnt_inc_s    = CNT_W'(sat_inc(64'(cnt_q), CNT_MAX));
    cnt_at_max_s = (64'(cnt_q) == CNT_MAX);
  end

  // Measurement FSM and status register next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    missed_d = missed_q;
    ovf_d    = ovf_q;
    errq_d   = errq_q | drop_s;
    push_s   = 1'b0;
    width_s  = '0;
    if (abort_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if ((state_q != IDLE) && trig_sel_s) begin
        missed_d = 32'(sat_inc(64'(missed_q), MISSED_MAX));
      end else begin
        missed_d = missed_q;
      end
      case (state_q)
        IDLE: begin
          if (trig_sel_s) begin
            cnt_d = '0;
            if (inp_rise_s) begin
              delay_d = '0;
              state_d = HIGH;
            end else begin
              state_d = WAIT_RISE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_RISE: begin
          ovf_d = ovf_q | cnt_at_max_s;
          if (inp_rise_s) begin
            delay_d = cnt_inc_s;
            cnt_d   = '0;
            state_d = HIGH;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        HIGH: begin
          ovf_d = ovf_q | cnt_at_max_s;
          if (inp_fall_s) begin
            width_s = cnt_inc_s;
            push_s  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // A fresh enable starts from a clean status.
    if (en_rise_s) begin
      missed_d = '0;
      ovf_d    = 1'b0;
      errq_d   = 1'b0;
    end else begin
      errq_d = errq_q | drop_s;
    end
  end

  // State, edge and status registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      delay_q  <= '0;
      missed_q <= '0;
      trig_q   <= 1'b0;
      inp_q    <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      errq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      missed_q <= missed_d;
      trig_q   <= trig_d;
      inp_q    <= inp_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      errq_q   <= errq_d;
    end
  end

  pulse_measure_fifo #(
    .DW (2*CNT_W),
    .AW (QUEUE_AW)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (en_rise_s),
    .push_i    (push_s),
    .data_i    ({delay_q, width_s}),
    .pop_i     (ready_i),
    .data_o    (fifo_data_s),
    .valid_o   (valid_o),
    .count_o   (fifo_count_s),
    .drop_o    (drop_s)
  );

  assign delay_o      = fifo_data_s[2*CNT_W-1:CNT_W];
  assign width_o      = fifo_data_s[CNT_W-1:0];
  assign QUEUE        = 32'(fifo_count_s);
  assign MISSED_CNT   = missed_q;
  assign ERR_OVERFLOW = {31'd0, ovf_q};
  assign ERR_QUEUE    = {31'd0, errq_q};

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
Receive-side counterpart of the pulse generator. It takes a reference trigger and a pulse train, then measures two values per pulse: the delay from the selected trigger edge to the pulse rising edge, and the pulse high width, both in clk_i cycles. Each (delay, width) pair is queued in an internal FIFO and read out through a valid/ready handshake. The block sits on the position/bit bus alongside pulse, and is used to characterise or loop-back-check generated pulses.

Parameters:
CNT_W, 48, width of the delay/width counters and output fields
QUEUE_AW, 4, FIFO address width; depth = 2**QUEUE_AW entries

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  measurement enable; rising edge clears queue and status
trig_i  in  1  reference trigger
inp_i  in  1  pulse to measure
TRIG_EDGE  in  2  0=rising, 1=falling, 2=both, 3=rising
TRIG_EDGE_WSTB  in  1  register write strobe; aborts an in-flight measurement
delay_o  out  CNT_W  head-of-queue delay
width_o  out  CNT_W  head-of-queue width
valid_o  out  1  queue non-empty
ready_i  in  1  consumer accept; pop when valid_o & ready_i
QUEUE  out  32  entries held, zero-extended
MISSED_CNT  out  32  triggers ignored while busy, saturating
ERR_OVERFLOW  out  32  bit0 sticky: a counter saturated
ERR_QUEUE  out  32  bit0 sticky: an entry was dropped because the queue was full

Behaviour:
- Reset (async, reset_n_i=0): state IDLE, counters 0, FIFO empty, valid_o=0, delay_o/width_o=0, all status regs 0, edge registers 0.
- Edge detect: trig_q/inp_q register trig_i/inp_i. An edge in cycle n means the sampled value differs from the registered one in n. All decisions use these registered comparisons.
- FSM:
  - IDLE: on a selected trig edge with enable_i=1, clear cnt and go to WAIT_RISE. If inp rises in that same cycle, go straight to HIGH with delay=0.
  - WAIT_RISE: cnt increments each cycle. On inp rise, latch delay=cnt+1, clear cnt, go to HIGH. A level already high at trigger time is ignored until the next rise.
  - HIGH: cnt increments. On inp fall, width=cnt+1, push {delay,width}, return to IDLE.
- Counters saturate at 2**CNT_W-1 and set ERR_OVERFLOW. The saturated value is stored.
- A selected trig edge in WAIT_RISE or HIGH is ignored and increments MISSED_CNT, saturating at 2**32-1.
- enable_i low, or TRIG_EDGE_WSTB=1: return to IDLE and discard the partial measurement. FIFO contents stay readable.
- enable_i rising edge: flush FIFO and clear MISSED_CNT, ERR_OVERFLOW and ERR_QUEUE in one cycle. That cycle does not start a measurement.
- FIFO:
  - Registered outputs: an entry pushed in cycle n gives valid_o=1 from cycle n+1.
  - Pop advances the head on the clock edge; the next entry appears the following cycle.
  - Push and pop in the same cycle are both honoured, including when full, and QUEUE is unchanged.
  - Push when full with no pop: entry dropped, ERR_QUEUE=1.
  - Pop when empty: ignored.
  - delay_o/width_o hold their last value when empty.
- QUEUE updates one cycle after a push/pop.

Decomposition:
- Shared pulse_pkg holds:
  - TRIG_EDGE encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - FSM state encoding (IDLE, WAIT_RISE, HIGH);
  - a saturating-increment function.
- One sub-module, pulse_measure_fifo: synchronous FIFO of width 2*CNT_W, with registered outputs and count, shared reset.

Test Plan:
- TRIG_EDGE=0, trig rise at ts10, inp rise ts15, inp fall ts20, ready_i=1 -> one entry delay=5 width=5, valid_o high at ts21 for one cycle.
- trig and inp rise at ts30, inp fall ts31 -> delay=0 width=1.
- TRIG_EDGE=2, trig falls at ts40, inp high ts42..ts50 -> delay=2 width=8. A second trig rise at ts45 -> MISSED_CNT=1, entry unchanged.
- QUEUE_AW=4, ready_i=0, 17 pulses -> QUEUE=16, ERR_QUEUE=1; draining returns pulses 1..16 in order, QUEUE=0.
- CNT_W=8, inp high 300 cycles -> width=255, ERR_OVERFLOW=1.
- enable_i low mid-HIGH -> no entry. Re-enable -> MISSED_CNT=0, ERR_*=0, QUEUE=0. reset_n_i asserted mid-WAIT_RISE -> all outputs 0 immediately.
